obi_axi4l_bridge: RTL and testbench

- Master-side bridge: converts the Ibex core's request/grant/rvalid load-store (or instruction-fetch) interface into single AXI4-Lite transactions.
- Sits directly upstream of the AXI4-Lite slaves (dual-port RAM, peripherals) on the SoC fabric and drives their axi4l_if.
- One outstanding transaction at a time.
- Responses to the core are registered.

---
 rtl/axi4l_pkg.sv | 20 ++
 rtl/axi4l_if.sv | 45 ++++
 rtl/obi_axi4l_bridge.sv | 165 ++++++++++++++++
 tb/tb_obi_axi4l_bridge.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types used by the fabric masters and slaves.
package axi4l_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  // SLVERR and DECERR both carry bit 1 set; OKAY/EXOKAY are successes.
  function automatic logic resp_is_err(input resp_t r);
    return (r == RESP_SLVERR) || (r == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bundle with clock and active-low reset carried alongside the channels.
interface axi4l_if (
  input logic aclk,
  input logic aresetn
);
  import axi4l_pkg::*;

  addr_t      awaddr;
  logic [2:0] awprot;
  logic       awvalid;
  logic       awready;
  data_t      wdata;
  strb_t      wstrb;
  logic       wvalid;
  logic       wready;
  resp_t      bresp;
  logic       bvalid;
  logic       bready;
  addr_t      araddr;
  logic [2:0] arprot;
  logic       arvalid;
  logic       arready;
  data_t      rdata;
  resp_t      rresp;
  logic       rvalid;
  logic       rready;

  modport master (
    input  aclk, aresetn,
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  aclk, aresetn,
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/obi_axi4l_bridge.sv
// Ibex req/gnt/rvalid port to single-outstanding AXI4-Lite master.
// Optional response timeout with DRAIN recovery: define AXI4L_BRIDGE_TIMEOUT_EN.
module obi_axi4l_bridge
  import axi4l_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  axi4l_if.master axi,
  input  logic    req_i,
  output logic    gnt_o,
  input  logic    we_i,
  input  strb_t   be_i,
  input  addr_t   addr_i,
  input  data_t   wdata_i,
  output logic    rvalid_o,
  output data_t   rdata_o,
  output logic    err_o
);

`ifdef AXI4L_BRIDGE_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic             timed_out;
`else
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  logic unused_timeout;
`endif

  state_t state;
  addr_t  addr_q;
  data_t  wdata_q;
  strb_t  be_q;
  logic   awvalid_q;
  logic   wvalid_q;
  logic   arvalid_q;
  logic   b_wait;
  logic   r_wait;
  logic   bready;
  logic   rready;
  logic   b_hs;
  logic   r_hs;

`ifdef AXI4L_BRIDGE_TIMEOUT_EN
  // A timed-out transaction still owns its response channel until DRAIN consumes it.
  assign b_wait    = (state == WRITE) || ((state == DRAIN) && we_q);
  assign r_wait    = (state == READ)  || ((state == DRAIN) && !we_q);
  assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));
`else
  assign b_wait         = (state == WRITE);
  assign r_wait         = (state == READ);
  assign unused_timeout = ^TIMEOUT;
`endif

  assign bready = b_wait && !awvalid_q && !wvalid_q;
  assign rready = r_wait && !arvalid_q;
  assign b_hs   = axi.bvalid && bready;
  assign r_hs   = axi.rvalid && rready;
  assign gnt_o  = axi.aresetn && (state == IDLE) && req_i;

  assign axi.awaddr  = addr_q;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = be_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready;
  assign axi.araddr  = addr_q;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready;

  // Request capture: payload only, qualified by the grant
  always_ff @(posedge axi.aclk) begin
    if (gnt_o) begin
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      be_q    <= be_i;
    end
  end

  // Control FSM: channel valids, response pulse and state
  always_ff @(posedge axi.aclk or negedge axi.aresetn) begin
    if (!axi.aresetn) begin
      state     <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
`ifdef AXI4L_BRIDGE_TIMEOUT_EN
      cnt       <= '0;
      we_q      <= 1'b0;
`endif
    end else begin
      rvalid_o <= 1'b0;
      if (awvalid_q && axi.awready) awvalid_q <= 1'b0;
      if (wvalid_q && axi.wready)   wvalid_q  <= 1'b0;
      if (arvalid_q && axi.arready) arvalid_q <= 1'b0;

      unique case (state)
        IDLE: begin
          if (req_i) begin
            if (we_i) begin
              state     <= WRITE;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state     <= READ;
              arvalid_q <= 1'b1;
            end
`ifdef AXI4L_BRIDGE_TIMEOUT_EN
            we_q <= we_i;
            cnt  <= '0;
`endif
          end
        end
        WRITE: begin
          if (b_hs) begin
            state    <= IDLE;
            rvalid_o <= 1'b1;
            err_o    <= resp_is_err(axi.bresp);
          end
`ifdef AXI4L_BRIDGE_TIMEOUT_EN
          else if (timed_out) begin
            state    <= DRAIN;
            rvalid_o <= 1'b1;
            err_o    <= 1'b1;
            rdata_o  <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        READ: begin
          if (r_hs) begin
            state    <= IDLE;
            rvalid_o <= 1'b1;
            rdata_o  <= axi.rdata;
            err_o    <= resp_is_err(axi.rresp);
          end
`ifdef AXI4L_BRIDGE_TIMEOUT_EN
          else if (timed_out) begin
            state    <= DRAIN;
            rvalid_o <= 1'b1;
            err_o    <= 1'b1;
            rdata_o  <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
`ifdef AXI4L_BRIDGE_TIMEOUT_EN
        DRAIN: begin
          if (b_hs || r_hs) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_axi4l_bridge.sv
// Bench for obi_axi4l_bridge: behavioural AXI4-Lite slave plus word-level memory model.
module tb_obi_axi4l_bridge;
  import axi4l_pkg::*;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = 4'h0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  int vectors = 0;
  int miscompares = 0;

  axi4l_if bus (.aclk(clk), .aresetn(rst_n));

  obi_axi4l_bridge #(.TIMEOUT(TMO)) dut (
    .axi      (bus),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .we_i     (we_i),
    .be_i     (be_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  // ---------------- slave knobs and state ----------------
  int          aw_delay = 0;
  int          w_delay = 0;
  int          ar_delay = 0;
  logic        nores = 1'b0;
  logic        rerr = 1'b0;
  logic        berr = 1'b0;
  logic [31:0] rerr_data = 32'h0;
  int          aw_wait, w_wait, ar_wait;
  logic        aw_got, w_got, ar_pend;
  logic [31:0] smem [0:255];

  int          cyc = 0;
  int          aw_vcnt = 0;
  int          w_vcnt = 0;
  int          aw_hs_cyc = 0, w_hs_cyc = 0, b_hs_cyc = 0, ar_hs_cyc = 0;
  logic [31:0] log_awaddr = 32'h0, log_wdata = 32'h0, log_araddr = 32'h0;
  logic [3:0]  log_wstrb = 4'h0;
  logic        bready_bad = 1'b0;

  assign bus.awready = (aw_wait >= aw_delay);
  assign bus.wready  = (w_wait >= w_delay);
  assign bus.arready = (ar_wait >= ar_delay);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_pend <= 1'b0;
      bus.bvalid <= 1'b0; bus.rvalid <= 1'b0;
      bus.bresp <= RESP_OKAY; bus.rresp <= RESP_OKAY; bus.rdata <= 32'h0;
    end else begin
      if (bus.awvalid && bus.awready) begin aw_wait <= 0; aw_got <= 1'b1; end
      else if (bus.awvalid) aw_wait <= aw_wait + 1;
      if (bus.wvalid && bus.wready) begin w_wait <= 0; w_got <= 1'b1; end
      else if (bus.wvalid) w_wait <= w_wait + 1;
      if (!bus.bvalid && (aw_got || (bus.awvalid && bus.awready)) &&
          (w_got || (bus.wvalid && bus.wready)) && !nores) begin
        bus.bvalid <= 1'b1;
        bus.bresp  <= berr ? RESP_SLVERR : RESP_OKAY;
        aw_got <= 1'b0; w_got <= 1'b0;
        if (!berr)
          for (int i = 0; i < 4; i++)
            if (bus.wstrb[i]) smem[bus.awaddr[9:2]][8*i +: 8] <= bus.wdata[8*i +: 8];
      end else if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;

      if (bus.arvalid && bus.arready) begin ar_wait <= 0; ar_pend <= 1'b1; end
      else if (bus.arvalid) ar_wait <= ar_wait + 1;
      if (!bus.rvalid && (ar_pend || (bus.arvalid && bus.arready)) && !nores) begin
        bus.rvalid <= 1'b1;
        bus.rdata  <= rerr ? rerr_data : smem[bus.araddr[9:2]];
        bus.rresp  <= rerr ? RESP_SLVERR : RESP_OKAY;
        ar_pend <= 1'b0;
      end else if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.awvalid) aw_vcnt <= aw_vcnt + 1;
    if (bus.wvalid) w_vcnt <= w_vcnt + 1;
    if (bus.awvalid && bus.awready) begin aw_hs_cyc <= cyc; log_awaddr <= bus.awaddr; end
    if (bus.wvalid && bus.wready) begin w_hs_cyc <= cyc; log_wdata <= bus.wdata; log_wstrb <= bus.wstrb; end
    if (bus.bvalid && bus.bready) b_hs_cyc <= cyc;
    if (bus.arvalid && bus.arready) begin ar_hs_cyc <= cyc; log_araddr <= bus.araddr; end
    if (bus.bready && (bus.awvalid || bus.wvalid)) bready_bad <= 1'b1;
  end

  // ---------------- reference model ----------------
  logic [31:0] mdl [logic [31:0]];
  logic [31:0] exp_rdata = 32'h0;
  int          gcyc = 0;

  function automatic void model_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] w;
    w = mdl.exists(a >> 2) ? mdl[a >> 2] : 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
    mdl[a >> 2] = w;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return mdl.exists(a >> 2) ? mdl[a >> 2] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction; lat counts cycles from grant to rvalid_o (-1 if none).
  task automatic txn(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat, output logic dbl);
    int k;
    @(negedge clk);
    req_i = 1'b1; we_i = we; be_i = be; addr_i = a; wdata_i = wd;
    #1;
    k = 0;
    while (gnt_o !== 1'b1 && k < 20) begin @(negedge clk); #1; k++; end
    gcyc = cyc;
    @(negedge clk);
    req_i = 1'b0;
    lat = 1;
    while (rvalid_o !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    rd = rdata_o; er = err_o;
    if (lat >= 200) lat = -1;
    @(negedge clk);
    dbl = rvalid_o;
  endtask

  logic [31:0] rd, a, wd;
  logic        er, dbl, we, inj, first_rv_gnt, drop, seen;
  logic [3:0]  be;
  int          lat, aw0, w0, got_rv, gnts, cnt_rv, cnt_ar;
  logic [31:0] rv_data [2];

  initial begin
    // reset state, with a request pending to confirm the grant is gated
    req_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_rvalid_err", {30'h0, rvalid_o, err_o}, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_bus_ctl", {27'h0, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 32'h0);
    req_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // full write with zero-wait slave
    txn(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er, lat, dbl);
    model_write(32'h10, 4'hF, 32'hDEADBEEF);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_err", 32'(er), 32'h0);
    chk("wr_rdata_hold", rd, exp_rdata);
    chk("wr_single_pulse", 32'(dbl), 32'h0);
    chk("wr_aw_cyc", 32'(aw_hs_cyc - gcyc), 32'd1);
    chk("wr_w_cyc", 32'(w_hs_cyc - gcyc), 32'd1);
    chk("wr_b_cyc", 32'(b_hs_cyc - gcyc), 32'd2);
    chk("wr_awaddr", log_awaddr, 32'h10);
    chk("wr_wdata", log_wdata, 32'hDEADBEEF);
    chk("wr_wstrb", 32'(log_wstrb), 32'hF);

    txn(1'b0, 4'hF, 32'h10, 32'h0, rd, er, lat, dbl);
    exp_rdata = model_read(32'h10);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_data", rd, exp_rdata);
    chk("rd_data_abs", rd, 32'hDEADBEEF);
    chk("rd_ar_cyc", 32'(ar_hs_cyc - gcyc), 32'd1);

    // partial write
    txn(1'b1, 4'h2, 32'h10, 32'h0000AB00, rd, er, lat, dbl);
    model_write(32'h10, 4'h2, 32'h0000AB00);
    chk("pw_wstrb", 32'(log_wstrb), 32'h2);
    txn(1'b0, 4'hF, 32'h10, 32'h0, rd, er, lat, dbl);
    exp_rdata = model_read(32'h10);
    chk("pw_readback", rd, 32'hDEADABEF);
    chk("pw_model", rd, exp_rdata);

    // skewed handshakes: AW stalls 3 cycles, W accepted immediately
    aw_delay = 3;
    aw0 = aw_vcnt; w0 = w_vcnt;
    txn(1'b1, 4'hF, 32'h14, 32'h11223344, rd, er, lat, dbl);
    model_write(32'h14, 4'hF, 32'h11223344);
    aw_delay = 0;
    chk("sk_w_cyc", 32'(w_hs_cyc - gcyc), 32'd1);
    chk("sk_aw_cyc", 32'(aw_hs_cyc - gcyc), 32'd4);
    chk("sk_b_cyc", 32'(b_hs_cyc - gcyc), 32'd5);
    chk("sk_lat", 32'(lat), 32'd6);
    chk("sk_wvalid_cycles", 32'(w_vcnt - w0), 32'd1);
    chk("sk_awvalid_cycles", 32'(aw_vcnt - aw0), 32'd4);
    chk("sk_single_pulse", 32'(dbl), 32'h0);
    chk("sk_bready_order", 32'(bready_bad), 32'h0);

    // error response on read
    rerr = 1'b1; rerr_data = 32'h12345678;
    txn(1'b0, 4'hF, 32'h18, 32'h0, rd, er, lat, dbl);
    rerr = 1'b0;
    exp_rdata = 32'h12345678;
    chk("er_err", 32'(er), 32'h1);
    chk("er_rdata", rd, exp_rdata);

    // back-to-back reads with req held
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h10;
    #1;
    chk("b2b_gnt0", 32'(gnt_o), 32'h1);
    got_rv = 0; gnts = 1; first_rv_gnt = 1'b0; drop = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) addr_i = 32'h14;
      if (drop) begin req_i = 1'b0; drop = 1'b0; end
      #1;
      if (rvalid_o) begin
        if (got_rv < 2) rv_data[got_rv] = rdata_o;
        if (got_rv == 0) first_rv_gnt = gnt_o;
        got_rv++;
      end
      if (gnt_o && req_i) begin gnts++; drop = 1'b1; end
    end
    chk("b2b_rv_count", 32'(got_rv), 32'd2);
    chk("b2b_gnt_count", 32'(gnts), 32'd2);
    chk("b2b_gnt_with_rv", 32'(first_rv_gnt), 32'h1);
    chk("b2b_data0", rv_data[0], model_read(32'h10));
    chk("b2b_data1", rv_data[1], model_read(32'h14));
    exp_rdata = model_read(32'h14);

    // reset while ARVALID is held
    ar_delay = 10; nores = 1'b1;
    @(negedge clk); req_i = 1'b1; we_i = 1'b0; addr_i = 32'h18; #1;
    @(negedge clk); req_i = 1'b0;
    @(negedge clk);
    chk("mr_arvalid_pre", 32'(bus.arvalid), 32'h1);
    #2 rst_n = 1'b0; req_i = 1'b1; #1;
    chk("mr_arvalid", 32'(bus.arvalid), 32'h0);
    chk("mr_rvalid", 32'(rvalid_o), 32'h0);
    chk("mr_rready", 32'(bus.rready), 32'h0);
    chk("mr_gnt", 32'(gnt_o), 32'h0);
    req_i = 1'b0;
    @(negedge clk); rst_n = 1'b1; ar_delay = 0; nores = 1'b0;
    exp_rdata = 32'h0;
    cnt_rv = 0; cnt_ar = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rvalid_o) cnt_rv++;
      if (bus.arvalid) cnt_ar++;
    end
    chk("mr_no_rvalid", 32'(cnt_rv), 32'h0);
    chk("mr_no_reissue", 32'(cnt_ar), 32'h0);
    chk("mr_rdata_cleared", rdata_o, exp_rdata);
    txn(1'b0, 4'hF, 32'h14, 32'h0, rd, er, lat, dbl);
    exp_rdata = model_read(32'h14);
    chk("mr_after_lat", 32'(lat), 32'd3);
    chk("mr_after_data", rd, exp_rdata);

`ifdef AXI4L_BRIDGE_TIMEOUT_EN
    // silent slave: timeout response, then the late response is drained
    nores = 1'b1;
    txn(1'b0, 4'hF, 32'h10, 32'h0, rd, er, lat, dbl);
    chk("to_lat", 32'(lat), TMO + 1);
    chk("to_err", 32'(er), 32'h1);
    chk("to_rdata", rd, 32'h0);
    chk("to_single_pulse", 32'(dbl), 32'h0);
    chk("to_drain_rready", 32'(bus.rready), 32'h1);
    req_i = 1'b1; #1;
    chk("to_drain_gnt", 32'(gnt_o), 32'h0);
    req_i = 1'b0;
    nores = 1'b0;
    cnt_rv = 0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (rvalid_o) cnt_rv++; end
    chk("to_discard", 32'(cnt_rv), 32'h0);
    chk("to_idle_rready", 32'(bus.rready), 32'h0);
`else
    // silent slave: the bridge waits without limit
    nores = 1'b1;
    @(negedge clk); req_i = 1'b1; we_i = 1'b0; addr_i = 32'h14; #1;
    @(negedge clk); req_i = 1'b0;
    cnt_rv = 0;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (rvalid_o) cnt_rv++; end
    chk("nw_no_rvalid", 32'(cnt_rv), 32'h0);
    chk("nw_rready", 32'(bus.rready), 32'h1);
    nores = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      @(negedge clk);
      if (rvalid_o) begin seen = 1'b1; rd = rdata_o; er = err_o; end
    end
    chk("nw_rvalid", 32'(seen), 32'h1);
    chk("nw_rdata", rd, model_read(32'h14));
    chk("nw_err", 32'(er), 32'h0);
`endif

    txn(1'b0, 4'hF, 32'h10, 32'h0, rd, er, lat, dbl);
    exp_rdata = model_read(32'h10);
    chk("pre_rnd_data", rd, exp_rdata);

    // randomized traffic over eight words with random stalls and error injection
    for (int n = 0; n < 48; n++) begin
      aw_delay = $urandom_range(0, 3);
      w_delay  = $urandom_range(0, 3);
      ar_delay = $urandom_range(0, 3);
      if (n < 8) begin
        we = 1'b1; be = 4'hF; a = 32'h100 + 32'(n * 4); inj = 1'b0;
      end else begin
        we = 1'($urandom_range(0, 1));
        be = 4'($urandom_range(1, 15));
        a = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
        inj = ($urandom_range(0, 5) == 0);
      end
      wd = $urandom();
      if (we) berr = inj;
      else begin rerr = inj; rerr_data = $urandom(); end
      txn(we, be, a, wd, rd, er, lat, dbl);
      berr = 1'b0; rerr = 1'b0;
      chk("rnd_done", 32'(lat > 0), 32'h1);
      chk("rnd_pulse", 32'(dbl), 32'h0);
      chk("rnd_err", 32'(er), 32'(inj));
      if (we) begin
        if (!inj) model_write(a, be, wd);
        chk("rnd_awaddr", log_awaddr, a);
        chk("rnd_wstrb", 32'(log_wstrb), 32'(be));
        chk("rnd_wr_rdata_hold", rd, exp_rdata);
      end else begin
        exp_rdata = inj ? rerr_data : model_read(a);
        chk("rnd_araddr", log_araddr, a);
        chk("rnd_rdata", rd, exp_rdata);
      end
    end
    chk("bready_order_global", 32'(bready_bad), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #150000;
    $display("FAIL watchdog: observed no completion expected $finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
